// File: rtl/pixop_pkg.sv
// Shared definitions for the pixel point-op sequencer: datapath select codes and FSM states.
package pixop_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0] SEL_PASS     = 2'b00;
  localparam logic [1:0] SEL_BRIGHTEN = 2'b01;
  localparam logic [1:0] SEL_THRESH   = 2'b10;
  localparam logic [1:0] SEL_INVERT   = 2'b11;

endpackage

// File: rtl/pixop_out_stage.sv
// Output register of the pixel stream: captures the datapath result on each input handshake.
// Latency 1 cycle; holds out_byte while out_valid=1 and out_ready=0.
module pixop_out_stage (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] load_byte,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [7:0] out_byte
);

  // A load in the same cycle as an output handshake keeps the stream full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_byte  <= 8'h00;
    end else if (load) begin
      out_valid <= 1'b1;
      out_byte  <= load_byte;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pixel_op_sequencer.sv
// Frame sequencer streaming pixels through an external point-op datapath, one pixel/cycle, 1-cycle latency.
// in_ready drops under output backpressure; optional PIXOP_CHECKSUM_EN adds a 16-bit output checksum.
module pixel_op_sequencer #(
  parameter int CNT_W = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       cfg_select,
  input  logic [7:0]       cfg_value,
  input  logic [7:0]       cfg_threshold,
  input  logic [CNT_W-1:0] cfg_num_pixels,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_byte,
  output logic [1:0]       dp_select,
  output logic [7:0]       dp_value,
  output logic [7:0]       dp_threshold,
  output logic [7:0]       dp_inbyte,
  input  logic [7:0]       dp_outbyte,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_byte,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pix_count
`ifdef PIXOP_CHECKSUM_EN
  ,
  output logic [15:0]      checksum
`endif
);

  import pixop_pkg::*;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] remaining;
  logic             in_hs;
  logic             out_hs;
  logic             start_acc;

  assign in_ready  = (state == ST_RUN) && (remaining != '0) && (!out_valid || out_ready);
  assign in_hs     = in_valid && in_ready;
  assign out_hs    = out_valid && out_ready;
  assign start_acc = (state == ST_IDLE) && start;
  // Gated by state so the datapath input is quiet outside a frame and during reset.
  assign dp_inbyte = (state == ST_RUN) ? in_byte : 8'h00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      remaining    <= '0;
      pix_count    <= '0;
      dp_select    <= 2'b00;
      dp_value     <= 8'h00;
      dp_threshold <= 8'h00;
    end else begin
      done <= 1'b0;
      if (in_hs)  remaining <= remaining - CNT_ONE;
      if (out_hs) pix_count <= pix_count + CNT_ONE;
      case (state)
        ST_IDLE: begin
          if (start) begin
            dp_select    <= cfg_select;
            dp_value     <= cfg_value;
            dp_threshold <= cfg_threshold;
            pix_count    <= '0;
            remaining    <= cfg_num_pixels;
            if (cfg_num_pixels != '0) begin
              state <= ST_RUN;
              busy  <= 1'b1;
            end else begin
              state <= ST_DONE;
              done  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          // Frame ends when the final pixel leaves, not when it enters.
          if (out_hs && remaining == '0) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  pixop_out_stage u_out_stage (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (in_hs),
    .load_byte (dp_outbyte),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_byte  (out_byte)
  );

`ifdef PIXOP_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         checksum <= 16'h0000;
    else if (start_acc) checksum <= 16'h0000;
    else if (out_hs)    checksum <= checksum + {8'h00, out_byte};
  end
`else
  logic unused_start_acc;
  assign unused_start_acc = start_acc;
`endif

endmodule

// File: tb/tb_pixel_op_sequencer.sv
// Randomized self-checking bench for pixel_op_sequencer against a frame-level reference model.
module tb_pixel_op_sequencer;
  import pixop_pkg::*;

  localparam int CNT_W = 17;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [1:0]       cfg_select;
  logic [7:0]       cfg_value;
  logic [7:0]       cfg_threshold;
  logic [CNT_W-1:0] cfg_num_pixels;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_byte;
  logic [1:0]       dp_select;
  logic [7:0]       dp_value;
  logic [7:0]       dp_threshold;
  logic [7:0]       dp_inbyte;
  logic [7:0]       dp_outbyte;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_byte;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] pix_count;
`ifdef PIXOP_CHECKSUM_EN
  logic [15:0]      checksum;
`endif

  always #5 clk = ~clk;

  // Point operation applied per pixel: used both as the bench's datapath and by the model.
  function automatic logic [7:0] point_op(input logic [1:0] s, input logic [7:0] v, input logic [7:0] t,
                                          input logic [7:0] x);
    int sum;
    case (s)
      2'b00:   return x;
      2'b01:   begin sum = int'(x) + int'(v); return (sum > 255) ? 8'hFF : sum[7:0]; end
      2'b10:   return (x >= t) ? 8'hFF : 8'h00;
      default: return ~x;
    endcase
  endfunction

  assign dp_outbyte = point_op(dp_select, dp_value, dp_threshold, dp_inbyte);

  pixel_op_sequencer #(.CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .cfg_select     (cfg_select),
    .cfg_value      (cfg_value),
    .cfg_threshold  (cfg_threshold),
    .cfg_num_pixels (cfg_num_pixels),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_byte        (in_byte),
    .dp_select      (dp_select),
    .dp_value       (dp_value),
    .dp_threshold   (dp_threshold),
    .dp_inbyte      (dp_inbyte),
    .dp_outbyte     (dp_outbyte),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_byte       (out_byte),
    .busy           (busy),
    .done           (done),
    .pix_count      (pix_count)
`ifdef PIXOP_CHECKSUM_EN
    ,
    .checksum       (checksum)
`endif
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int         cyc = 0;
  logic [7:0] src_q[$];
  logic [7:0] got_q[$];
  int         got_cyc[$];
  int         in_hs_cnt = 0;
  bit         stall_prev = 0;
  logic [7:0] held_byte;

  always @(posedge clk) cyc++;

  // Stream monitor: records accepted outputs and checks hold-under-stall.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 0;
    end else begin
      if (stall_prev) chk("out_hold", out_byte, held_byte);
      if (out_valid && out_ready) begin
        got_q.push_back(out_byte);
        got_cyc.push_back(cyc);
      end
      if (in_valid && in_ready) in_hs_cnt++;
      stall_prev = out_valid && !out_ready;
      held_byte  = out_byte;
    end
  end

  task automatic run_frame(input int num, input logic [1:0] sel, input logic [7:0] val, input logic [7:0] thr,
                           input int p_valid, input int p_ready, input int stall_at, input bit cfg_chg,
                           input bit chk_spacing);
    logic [7:0]  exp_q[$];
    logic [15:0] sum;
    int          idx, k;
    bit          hs, fin;
    for (int i = src_q.size(); i < num; i++) src_q.push_back(8'($urandom));
    sum = 16'h0000;
    for (int i = 0; i < num; i++) begin
      exp_q.push_back(point_op(sel, val, thr, src_q[i]));
      sum = sum + {8'h00, exp_q[i]};
    end
    @(posedge clk); #1;
    got_q.delete(); got_cyc.delete(); in_hs_cnt = 0;
    cfg_select = sel; cfg_value = val; cfg_threshold = thr;
    cfg_num_pixels = CNT_W'(num);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    idx = 0; fin = 0; k = 0;
    while (!fin && k < 3000) begin
      in_valid  = (idx < num) ? ($urandom_range(99) < p_valid) : 1'b1;
      in_byte   = (idx < num) ? src_q[idx] : 8'($urandom);
      out_ready = (k >= stall_at && k < stall_at + 5) ? 1'b0 : ($urandom_range(99) < p_ready);
      if (cfg_chg && k == 2) begin
        cfg_select = 2'b01; cfg_value = 8'($urandom); cfg_threshold = 8'($urandom);
        cfg_num_pixels = CNT_W'($urandom_range(50));
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (k == 0) chk("busy_after_start", busy, num != 0);
      if (k >= stall_at && k < stall_at + 5 && out_valid) chk("stall_in_ready", in_ready, 1'b0);
      hs = in_valid && in_ready;
      if (done) begin
        fin = 1;
        if (num == 0) chk("zero_len_latency", k, 0);
        chk("busy_at_done", busy, 1'b0);
        chk("pix_count", pix_count, num);
        chk("in_accepted", in_hs_cnt, num);
        chk("out_count", got_q.size(), num);
        for (int i = 0; i < num && i < got_q.size(); i++) chk("out_byte", got_q[i], exp_q[i]);
        if (chk_spacing)
          for (int i = 1; i < got_cyc.size(); i++) chk("out_spacing", got_cyc[i] - got_cyc[i-1], 1);
        chk("dp_select_held", dp_select, sel);
        chk("dp_value_held", dp_value, val);
        chk("dp_thr_held", dp_threshold, thr);
`ifdef PIXOP_CHECKSUM_EN
        chk("checksum", checksum, sum);
`endif
      end
      @(posedge clk); #1;
      if (hs) idx++;
      k++;
    end
    start = 1'b0;
    if (!fin) chk("done_timeout", 0, 1);
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("done_pulse_end", done, 1'b0);
    chk("idle_not_busy", busy, 1'b0);
    chk("dp_select_idle", dp_select, sel);
    src_q.delete();
  endtask

  initial begin
    int cnt;
    rst_n = 1'b0; start = 1'b0; cfg_select = 2'b00; cfg_value = 8'h00; cfg_threshold = 8'h00;
    cfg_num_pixels = '0; in_valid = 1'b1; in_byte = 8'hA5; out_ready = 1'b1;
    #12;
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_byte", out_byte, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_pix_count", pix_count, 0);
    chk("rst_dp_inbyte", dp_inbyte, 8'h00);
    chk("rst_dp_select", dp_select, 2'b00);
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;

    // Basic invert frame with full throughput
    src_q = '{8'h00, 8'h0F, 8'hFF};
    run_frame(3, SEL_INVERT, 8'h00, 8'h00, 100, 100, 1000, 0, 1);
    chk("basic_size", got_q.size(), 3);
    if (got_q.size() == 3) begin
      chk("basic_o0", got_q[0], 8'hFF);
      chk("basic_o1", got_q[1], 8'hF0);
      chk("basic_o2", got_q[2], 8'h00);
    end

    // Five-cycle output stall mid-frame
    run_frame(8, SEL_INVERT, 8'h00, 8'h00, 100, 100, 3, 0, 0);

    // Zero-length frame
    run_frame(0, SEL_INVERT, 8'h00, 8'h00, 100, 100, 1000, 0, 0);

    // cfg and start toggled mid-frame must not disturb the latched frame
    run_frame(6, SEL_INVERT, 8'h12, 8'h34, 80, 80, 1000, 1, 0);

    // Reset after 2 of 5 pixels
    @(posedge clk); #1;
    cfg_select = SEL_INVERT; cfg_num_pixels = CNT_W'(5); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1; out_ready = 1'b1; cnt = 0;
    for (int k = 0; k < 50 && cnt < 2; k++) begin
      in_byte = 8'($urandom);
      @(negedge clk);
      if (in_valid && in_ready) cnt++;
      @(posedge clk); #1;
    end
    chk("pre_rst_inputs", cnt, 2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", in_ready, 1'b0);
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_out_byte", out_byte, 8'h00);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_done", done, 1'b0);
    chk("mid_rst_pix_count", pix_count, 0);
    chk("mid_rst_dp_select", dp_select, 2'b00);
    chk("mid_rst_dp_value", dp_value, 8'h00);
    chk("mid_rst_dp_thr", dp_threshold, 8'h00);
    chk("mid_rst_dp_inbyte", dp_inbyte, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("no_resume_busy", busy, 1'b0);
    chk("no_resume_in_ready", in_ready, 1'b0);
    in_valid = 1'b0;
    run_frame(2, SEL_INVERT, 8'h00, 8'h00, 100, 100, 1000, 0, 1);

    // Two 0x00 inputs inverted to 0xFF, 0xFF
    src_q = '{8'h00, 8'h00};
    run_frame(2, SEL_INVERT, 8'h00, 8'h00, 100, 100, 1000, 0, 0);
`ifdef PIXOP_CHECKSUM_EN
    chk("checksum_ff_ff", checksum, 16'h01FE);
`endif

    // Randomized frames across all operations
    for (int f = 0; f < 8; f++)
      run_frame($urandom_range(1, 24), 2'($urandom), 8'($urandom), 8'($urandom),
                $urandom_range(30, 100), $urandom_range(30, 100), $urandom_range(0, 10), f[0], 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/pixel_op_sequencer.md
PIXEL_OP_SEQUENCER -- requirements
Module: pixel_op_sequencer

Interface
REQ-001 SHALL have parameter CNT_W, default 17, the width of the pixel counter (frames up to 100001 pixels).
REQ-002 SHALL have port clk  input  1  the only clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port start  input  1  one-cycle frame start request.
REQ-005 SHALL have port cfg_select / cfg_value / cfg_threshold  input  2/8/8  frame operation, brightness value and threshold.
REQ-006 SHALL have port cfg_num_pixels  input  CNT_W  number of pixels in the frame.
REQ-007 SHALL have ports in_valid / in_ready / in_byte  input/output/input  1/1/8  input pixel stream.
REQ-008 SHALL have ports dp_select / dp_value / dp_threshold / dp_inbyte  output  2/8/8/8  drive the combinational point-op datapath.
REQ-009 SHALL have port dp_outbyte  input  8  datapath result for dp_inbyte.
REQ-010 SHALL have ports out_valid / out_ready / out_byte  output/input/output  1/1/8  output pixel stream.
REQ-011 SHALL have ports busy / done / pix_count  output  1/1/CNT_W  frame active, one-cycle completion pulse, and pixels delivered.

Function
REQ-012 SHALL implement states IDLE, RUN, DONE.
- IDLE->RUN: start=1 and cfg_num_pixels!=0.
- IDLE->DONE: start=1 and cfg_num_pixels==0.
- RUN->DONE: the last output is accepted.
- DONE->IDLE: unconditionally after one cycle.
REQ-013 SHALL latch cfg_* on the accepted start cycle; dp_select/dp_value/dp_threshold hold the latched values for the whole frame and cfg changes mid-frame have no effect.
REQ-014 SHALL ignore start while the state is RUN or DONE.
REQ-015 SHALL drive in_ready = (state==RUN) && (remaining>0) && (!out_valid || out_ready); this term is combinational, so back-to-back transfers run at one pixel per cycle.
REQ-016 SHALL drive dp_inbyte = in_byte combinationally; on an input handshake it SHALL register dp_outbyte into out_byte and set out_valid the next cycle (latency 1 cycle).
REQ-017 SHALL clear out_valid on an output handshake unless a new input handshake occurs in the same cycle, in which case out_valid stays 1 and out_byte updates.
REQ-018 SHALL hold out_byte stable while out_valid=1 and out_ready=0.
REQ-019 SHALL decrement remaining on each input handshake and increment pix_count on each output handshake; pix_count clears on an accepted start.
REQ-020 SHALL assert done for exactly one cycle, in state DONE; busy=1 exactly in RUN.
REQ-021 SHALL accept no further input once remaining==0, even if in_valid=1.

Reset
REQ-022 SHALL, on rst_n low at any time including mid-frame, immediately force: state IDLE, in_ready 0, out_valid 0, out_byte 0, dp_* 0, busy 0, done 0, pix_count 0, remaining 0.
REQ-023 SHALL discard any partial frame on reset and require a new start afterwards.

Configuration
REQ-024 SHALL, when PIXOP_CHECKSUM_EN is defined, add output checksum [15:0]: the modulo-2^16 sum of accepted out_byte values, cleared on start and valid from the done pulse until the next start.
REQ-025 SHALL, when PIXOP_CHECKSUM_EN is undefined, omit the checksum port and its logic entirely.

Structure
REQ-026 SHALL take the select encodings (00 pass, 01 brighten, 10 threshold, 11 invert) and the state enum from shared package pixop_pkg.
REQ-027 SHALL place the output register/handshake (REQ-016..018) in sub-module pixop_out_stage.

Verification
All scenarios use the datapath in invert mode (select=11) unless stated.
REQ-028 Basic frame: start with num_pixels=3; inputs 0x00, 0x0F, 0xFF, in_valid and out_ready held 1 -> outputs 0xFF, 0xF0, 0x00 on consecutive cycles; done pulses once; pix_count=3.
REQ-029 Backpressure: out_ready=0 for 5 cycles mid-frame -> in_ready=0, out_byte held, no pixel lost or duplicated.
REQ-030 Zero-length frame: num_pixels=0 -> done one cycle after start; busy never 1.
REQ-031 Config change: cfg_select changed to 01 mid-frame -> dp_select stays 11 until the next start.
REQ-032 Reset mid-frame: rst_n low after 2 of 5 pixels -> all outputs 0 in the same cycle; a new start of 2 pixels completes normally.
REQ-033 With PIXOP_CHECKSUM_EN: outputs 0xFF, 0xFF -> checksum=0x01FE at done.
